// File: rtl/dcache_wb_buffer.sv
// Dirty-line writeback buffer: queues evicted 256-bit lines, drains each as an
// 8-beat burst to the AXI bridge, and forwards pending lines to DCache refills.
module dcache_wb_buffer #(
  parameter int DEPTH      = 2,
  parameter int LINE_BEATS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [255:0] wr_data,
  output logic         wr_rdy,
  input  logic [31:0]  rd_addr,
  output logic         rd_hit,
  output logic [255:0] rd_hit_data,
  output logic         mem_wen,
  output logic [31:0]  mem_waddr,
  output logic [7:0]   mem_wlen,
  output logic [31:0]  mem_wdata,
  output logic         mem_wvalid,
  output logic         mem_wlast,
  input  logic         mem_wresp,
  input  logic         mem_bvalid,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t             state, state_nxt;
  logic [2:0]         beat, beat_nxt;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [DEPTH-1:0]   valid;
  logic [26:0]        addr_q [DEPTH];
  logic [255:0]       data_q [DEPTH];
  logic               push, pop;

  // Line offset bits are don't-care on both address inputs.
  logic unused_offsets;
  assign unused_offsets = ^{wr_addr[4:0], rd_addr[4:0]};

  assign wr_rdy   = (count < CNT_W'(DEPTH));
  assign push     = wr_req && wr_rdy;
  assign mem_wlen = 8'(LINE_BEATS - 1);
  assign empty    = (count == '0) && (state == IDLE);

  // Drain FSM: the burst always reads straight from the head entry, which cannot
  // be overwritten while it is valid, so no separate line latch is needed.
  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    pop        = 1'b0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wvalid = 1'b0;
    mem_wlast  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = BEAT;
          beat_nxt  = '0;
        end
      end
      BEAT: begin
        mem_wen    = 1'b1;
        mem_wvalid = 1'b1;
        mem_waddr  = {addr_q[head], 5'b0};
        mem_wdata  = data_q[head][{beat, 5'b0} +: 32];
        mem_wlast  = (beat == LAST_BEAT);
        if (mem_wresp) begin
          beat_nxt = beat + 3'd1;
          if (beat == LAST_BEAT) state_nxt = RESP;
        end
      end
      RESP: begin
        mem_wen   = 1'b1;
        mem_waddr = {addr_q[head], 5'b0};
        if (mem_bvalid) begin
          pop = 1'b1;
          if (count > CNT_W'(1)) begin
            state_nxt = BEAT;
            beat_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (pop) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      if (push) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: line storage is deliberately not reset; the valid bits gate every use,
  // and leaving the wide arrays reset-free keeps them plain RAM/flop banks.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= wr_addr[31:5];
      data_q[tail] <= wr_data;
    end
  end

  // Scan from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (addr_q[idx] == rd_addr[31:5])) begin
        rd_hit      = 1'b1;
        rd_hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed self-checking bench for dcache_wb_buffer (DEPTH=2): bursts, stall,
// backpressure, forwarding, simultaneous push/pop and asynchronous reset.
module tb_dcache_wb_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [255:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  rd_addr;
  logic         rd_hit;
  logic [255:0] rd_hit_data;
  logic         mem_wen;
  logic [31:0]  mem_waddr;
  logic [7:0]   mem_wlen;
  logic [31:0]  mem_wdata;
  logic         mem_wvalid;
  logic         mem_wlast;
  logic         mem_wresp;
  logic         mem_bvalid;
  logic         empty;

  int n_assert = 0;
  int n_fail   = 0;

  dcache_wb_buffer #(.DEPTH(2), .LINE_BEATS(8)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_hit_data(rd_hit_data),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wlen(mem_wlen),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wlast(mem_wlast),
    .mem_wresp(mem_wresp), .mem_bvalid(mem_bvalid), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Waits (bounded) for the burst, checks all 8 beats acking every ack_every-th
  // cycle, then optionally completes the response with a bvalid pulse.
  task automatic drain_line(input logic [31:0] addr, input logic [31:0] base,
                            input int ack_every, input bit do_resp);
    int n;
    n = 0;
    while (!mem_wvalid && n < 4) begin
      tick();
      n++;
    end
    check("burst_start", 256'(mem_wvalid), 256'(1));
    check("burst_waddr", 256'(mem_waddr), 256'(addr));
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < ack_every; c++) begin
        mem_wresp = (c == ack_every - 1);
        #1;
        check("beat_wdata", 256'(mem_wdata), 256'(base + 32'(b)));
        check("beat_wlast", 256'(mem_wlast), 256'(b == 7));
        tick();
      end
    end
    mem_wresp = 1'b0;
    check("resp_wvalid", 256'(mem_wvalid), 256'(0));
    check("resp_wen", 256'(mem_wen), 256'(1));
    if (do_resp) begin
      mem_bvalid = 1'b1;
      tick();
      mem_bvalid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; mem_wresp = 1'b0; mem_bvalid = 1'b0;
    #2;
    check("rst_wr_rdy", 256'(wr_rdy), 256'(1));
    check("rst_rd_hit", 256'(rd_hit), 256'(0));
    check("rst_hit_data", rd_hit_data, '0);
    check("rst_wen", 256'(mem_wen), 256'(0));
    check("rst_waddr", 256'(mem_waddr), 256'(0));
    check("rst_wdata", 256'(mem_wdata), 256'(0));
    check("rst_wvalid", 256'(mem_wvalid), 256'(0));
    check("rst_wlast", 256'(mem_wlast), 256'(0));
    check("rst_empty", 256'(empty), 256'(1));
    check("rst_wlen", 256'(mem_wlen), 256'(7));
    #10 rst = 1'b0;
    tick();

    // Single line with two-cycle push-to-wvalid latency
    wr_req = 1'b1; wr_addr = 32'h1C00_0040; wr_data = mk_line(32'h0);
    tick();
    wr_req = 1'b0;
    check("single_not_empty", 256'(empty), 256'(0));
    check("single_lat_wvalid0", 256'(mem_wvalid), 256'(0));
    tick();
    check("single_lat_wvalid1", 256'(mem_wvalid), 256'(1));
    drain_line(32'h1C00_0040, 32'h0, 1, 1'b1);
    check("single_empty", 256'(empty), 256'(1));
    check("single_wen_off", 256'(mem_wen), 256'(0));

    // Fill and stall: third line held while the buffer is full
    wr_req = 1'b1; wr_addr = 32'h2000_0000; wr_data = mk_line(32'h100);
    tick();
    wr_addr = 32'h2000_0020; wr_data = mk_line(32'h200);
    tick();
    check("full_wr_rdy", 256'(wr_rdy), 256'(0));
    wr_addr = 32'h2000_0040; wr_data = mk_line(32'h300);
    rd_addr = 32'h2000_0040;
    tick();
    tick();
    check("full_held_wr_rdy", 256'(wr_rdy), 256'(0));
    check("full_held_no_hit", 256'(rd_hit), 256'(0));
    drain_line(32'h2000_0000, 32'h100, 1, 1'b1);
    check("after_pop_wr_rdy", 256'(wr_rdy), 256'(1));
    tick();
    wr_req = 1'b0;
    check("third_accepted_full", 256'(wr_rdy), 256'(0));
    check("third_hit", 256'(rd_hit), 256'(1));
    check("third_hit_data", rd_hit_data, mk_line(32'h300));

    // Backpressure on line 2, then line 3 at full rate
    drain_line(32'h2000_0020, 32'h200, 3, 1'b1);
    drain_line(32'h2000_0040, 32'h300, 1, 1'b1);
    check("fill_empty", 256'(empty), 256'(1));

    // Forwarding: two lines at the same address, youngest wins
    rd_addr = 32'h8000_101C;
    wr_req = 1'b1; wr_addr = 32'h8000_1000; wr_data = mk_line(32'hA0);
    tick();
    wr_data = mk_line(32'hB0);
    #1;
    check("fwd_a_hit", 256'(rd_hit), 256'(1));
    check("fwd_a_data", rd_hit_data, mk_line(32'hA0));
    tick();
    wr_req = 1'b0;
    check("fwd_b_data", rd_hit_data, mk_line(32'hB0));
    rd_addr = 32'h8000_1020;
    #1;
    check("fwd_miss_hit", 256'(rd_hit), 256'(0));
    check("fwd_miss_data", rd_hit_data, '0);
    rd_addr = 32'h8000_101C;
    drain_line(32'h8000_1000, 32'hA0, 1, 1'b1);
    check("fwd_after_a_data", rd_hit_data, mk_line(32'hB0));
    drain_line(32'h8000_1000, 32'hB0, 1, 1'b1);
    check("fwd_drained_hit", 256'(rd_hit), 256'(0));
    check("fwd_drained_data", rd_hit_data, '0);

    // Simultaneous push and pop with one entry in RESP
    wr_req = 1'b1; wr_addr = 32'h3000_0000; wr_data = mk_line(32'hC0);
    tick();
    wr_req = 1'b0;
    drain_line(32'h3000_0000, 32'hC0, 1, 1'b0);
    check("sim_wr_rdy", 256'(wr_rdy), 256'(1));
    wr_req = 1'b1; wr_addr = 32'h3000_0020; wr_data = mk_line(32'hD0);
    mem_bvalid = 1'b1;
    tick();
    wr_req = 1'b0; mem_bvalid = 1'b0;
    check("sim_count1_wr_rdy", 256'(wr_rdy), 256'(1));
    check("sim_not_empty", 256'(empty), 256'(0));
    rd_addr = 32'h3000_0000;
    #1;
    check("sim_old_gone", 256'(rd_hit), 256'(0));
    rd_addr = 32'h3000_0020;
    #1;
    check("sim_new_data", rd_hit_data, mk_line(32'hD0));
    drain_line(32'h3000_0020, 32'hD0, 1, 1'b1);
    check("sim_empty", 256'(empty), 256'(1));

    // Asynchronous reset at beat 4
    wr_req = 1'b1; wr_addr = 32'h4000_0000; wr_data = mk_line(32'hE0);
    tick();
    wr_req = 1'b0;
    tick();
    mem_wresp = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_wresp = 1'b0;
    check("rstmid_beat4", 256'(mem_wdata), 256'(32'hE4));
    #2 rst = 1'b1;
    #1;
    check("rstmid_wvalid", 256'(mem_wvalid), 256'(0));
    check("rstmid_empty", 256'(empty), 256'(1));
    check("rstmid_wen", 256'(mem_wen), 256'(0));
    check("rstmid_wr_rdy", 256'(wr_rdy), 256'(1));
    tick();
    rst = 1'b0;
    mem_wresp = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_no_beat", 256'(mem_wvalid), 256'(0));
    end
    mem_wresp = 1'b0;
    check("post_rst_empty", 256'(empty), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Dirty-line writeback buffer between the DCache write port and the cache-to-AXI bridge.
- Accepts whole 256-bit evicted lines in a single cycle and queues them in FIFO order.
- Serialises each queued line into 8 x 32-bit beats on the bridge write channel.
- Forwards pending line data to DCache refills, so a refill never reads stale memory.

Parameters:
DEPTH, 2, number of line entries; power of two, minimum 2
LINE_BEATS, 8, 32-bit beats per line; fixed at 8 (256-bit line)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_req  in  1  DCache requests a line writeback
wr_addr  in  32  line address; bits [4:0] ignored
wr_data  in  256  line data; beat i = wr_data[32i+31:32i]
wr_rdy  out  1  buffer can accept a line this cycle
rd_addr  in  32  DCache refill address to check against pending lines
rd_hit  out  1  rd_addr line matches a valid entry
rd_hit_data  out  256  data of the matching entry
mem_wen  out  1  write burst in progress to the bridge
mem_waddr  out  32  burst base address {addr[31:5],5'b0}
mem_wlen  out  8  constant 8'd7
mem_wdata  out  32  current beat data
mem_wvalid  out  1  current beat valid
mem_wlast  out  1  current beat is beat 7
mem_wresp  in  1  bridge accepted current beat
mem_bvalid  in  1  burst write response complete
empty  out  1  no valid entries and drain FSM in IDLE

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries {valid, addr[31:5], data[255:0]}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Enqueue:
  - A push occurs when wr_req && wr_rdy.
  - The entry is written at tail, tail increments, and count increments the same cycle.
  - wr_rdy = (count < DEPTH), computed from registered count only.
  - A pop in the same cycle does not raise wr_rdy; when full, wr_rdy stays 0 for that cycle.
  - wr_req while wr_rdy=0 is ignored; DCache holds the request.
- Drain FSM states: IDLE, BEAT, RESP.
  - IDLE: if count>0, go to BEAT next cycle, beat counter=0, latch head entry.
  - BEAT:
    - mem_wen=1, mem_wvalid=1.
    - mem_wdata = head.data[32*beat+31 : 32*beat].
    - mem_wlast = (beat==7).
    - On mem_wresp: beat increments. If beat==7, go to RESP.
    - Without mem_wresp: all outputs hold.
  - RESP:
    - mem_wen=1, mem_wvalid=0.
    - On mem_bvalid: pop head (head++, count--).
    - Then go to BEAT if count-1>0 (beat=0), else IDLE.
  - mem_bvalid outside RESP is ignored. mem_wresp outside BEAT is ignored.
- Simultaneous push and pop:
  - count is unchanged.
  - Both pointers advance.
- Forwarding (combinational):
  - Compare rd_addr[31:5] with every valid entry, including the one being drained.
  - If several entries match, the youngest (closest to tail) wins.
  - rd_hit_data is 0 when rd_hit=0.
  - A push in the current cycle is not visible until the next cycle.
- Entry lifetime: an entry stays valid (and forwardable) until its bvalid pop.
- Reset:
  - Asynchronous; applies immediately, including mid-burst.
  - Pointers, count, and valid bits clear; the FSM returns to IDLE; in-flight data is discarded.
  - Output values during reset: wr_rdy=1, rd_hit=0, rd_hit_data=0, mem_wen=0, mem_waddr=0, mem_wdata=0, mem_wvalid=0, mem_wlast=0, empty=1. mem_wlen is always 7.
- Latency: a push to an empty buffer gives mem_wvalid=1 two cycles later (push edge, then IDLE->BEAT edge).

Test Plan:
- Single line: push addr 0x1C00_0040, data words 0x0..0x7. Ack every beat -> 8 beats of 0..7, waddr 0x1C00_0040, wlast only on word 7. bvalid -> empty=1.
- Fill and stall: push 3 lines with DEPTH=2 and no wresp -> wr_rdy=0 after the 2nd push, 3rd held. After the first bvalid, wr_rdy=1 the next cycle and the 3rd line is accepted.
- Backpressure: wresp only every 3rd cycle -> mem_wdata and beat stay stable between acks. Exactly 8 beats, wlast on the last beat.
- Forwarding: push 0x8000_1000 (A) then 0x8000_1000 (B), rd_addr=0x8000_101C -> rd_hit=1 with data B. After both drain -> rd_hit=0.
- Simultaneous: count=1 in RESP, bvalid and wr_req in the same cycle -> count stays 1, next burst starts with the new line.
- Reset mid-burst: assert rst at beat 4 -> mem_wvalid=0 and empty=1 immediately. After release, no further beats.
